// File: rtl/candy_vend_fsm_pkg.sv
// Shared constants and state encoding for the candy vending control core.
package candy_pkg;

    localparam int unsigned COIN_NICKEL    = 5;
    localparam int unsigned COIN_DIME      = 10;
    localparam int unsigned COIN_QUARTER   = 25;

    localparam int unsigned DEF_PRICE      = 65;
    localparam int unsigned DEF_MAX_CREDIT = 100;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        DISPENSE = 2'd1,
        CHANGE   = 2'd2
    } state_t;

endpackage

// File: rtl/candy_vend_fsm_if.sv
// Coin/button pulses in, credit and actuator drives out.
interface candy_vend_fsm_if #(
    parameter int unsigned CREDIT_W = 8
);
    logic                coin_5;
    logic                coin_10;
    logic                coin_25;
    logic                select;
    logic                cancel;
    logic [CREDIT_W-1:0] credit;
    logic                dispense;
    logic                change_nickel;
    logic                coin_reject;
    logic                insufficient;
    logic                busy;

    modport master (
        output coin_5, coin_10, coin_25, select, cancel,
        input  credit, dispense, change_nickel, coin_reject, insufficient, busy
    );

    modport slave (
        input  coin_5, coin_10, coin_25, select, cancel,
        output credit, dispense, change_nickel, coin_reject, insufficient, busy
    );
endinterface

// File: rtl/candy_vend_fsm_cycle_timer.sv
// Loadable down-counter; done is high whenever the count has reached zero.
module cycle_timer #(
    parameter int unsigned W = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         done
);

    logic [W-1:0] count;

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            count <= '0;
        else if (load)
            count <= load_val;
        else if (count != '0)
            count <= count - 1'b1;
    end

    always_comb done = (count == '0);

endmodule

// File: rtl/candy_vend_fsm.sv
// Vending control core: credit accumulation, dispense timing, nickel change train.
module candy_vend_fsm
    import candy_pkg::*;
#(
    parameter int unsigned PRICE       = DEF_PRICE,
    parameter int unsigned MAX_CREDIT  = DEF_MAX_CREDIT,
    parameter int unsigned CREDIT_W    = 8,
    parameter int unsigned DISP_CYCLES = 4,
    parameter int unsigned CHG_GAP     = 3
) (
    input  logic              clk,
    input  logic              reset,
    candy_vend_fsm_if.slave   bus
);

    localparam int unsigned SUM_W = CREDIT_W + 1;
    localparam int unsigned TMR_W = 8;

    state_t              state_q, state_d;
    logic [CREDIT_W-1:0] credit_q, credit_d;
    logic                dispense_q, change_q, reject_q, insuff_q, busy_q;
    logic                change_d, reject_d, insuff_d;
    logic                tmr_load, tmr_done;
    logic [TMR_W-1:0]    tmr_val;
    logic [SUM_W-1:0]    coin_sum, credit_sum;
    logic                coin_any;

    cycle_timer #(.W(TMR_W)) u_timer (
        .clk      (clk),
        .reset    (reset),
        .load     (tmr_load),
        .load_val (tmr_val),
        .done     (tmr_done)
    );

    // One extra bit so simultaneous coins on top of full credit cannot wrap.
    always_comb begin
        coin_sum   = (bus.coin_5  ? SUM_W'(COIN_NICKEL)  : '0)
                   + (bus.coin_10 ? SUM_W'(COIN_DIME)    : '0)
                   + (bus.coin_25 ? SUM_W'(COIN_QUARTER) : '0);
        credit_sum = {1'b0, credit_q} + coin_sum;
        coin_any   = bus.coin_5 | bus.coin_10 | bus.coin_25;
    end

    always_comb begin
        state_d  = state_q;
        credit_d = credit_q;
        change_d = 1'b0;
        reject_d = 1'b0;
        insuff_d = 1'b0;
        tmr_load = 1'b0;
        tmr_val  = '0;
        case (state_q)
            IDLE: begin
                if (bus.cancel) begin
                    reject_d = coin_any;
                    if (credit_q != '0) begin
                        state_d  = CHANGE;
                        credit_d = credit_q - CREDIT_W'(COIN_NICKEL);
                        change_d = 1'b1;
                        tmr_load = 1'b1;
                        tmr_val  = TMR_W'(CHG_GAP - 1);
                    end
                end else if (bus.select && credit_q >= CREDIT_W'(PRICE)) begin
                    reject_d = coin_any;
                    state_d  = DISPENSE;
                    credit_d = credit_q - CREDIT_W'(PRICE);
                    tmr_load = 1'b1;
                    tmr_val  = TMR_W'(DISP_CYCLES - 1);
                end else begin
                    insuff_d = bus.select;
                    if (coin_any) begin
                        if (credit_sum <= SUM_W'(MAX_CREDIT))
                            credit_d = credit_sum[CREDIT_W-1:0];
                        else
                            reject_d = 1'b1;
                    end
                end
            end
            DISPENSE: begin
                reject_d = coin_any;
                if (tmr_done) begin
                    if (credit_q != '0) begin
                        state_d  = CHANGE;
                        credit_d = credit_q - CREDIT_W'(COIN_NICKEL);
                        change_d = 1'b1;
                        tmr_load = 1'b1;
                        tmr_val  = TMR_W'(CHG_GAP - 1);
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            CHANGE: begin
                reject_d = coin_any;
                // Credit already hit zero on the last pulse: leave the following cycle.
                if (credit_q == '0) begin
                    state_d = IDLE;
                end else if (tmr_done) begin
                    credit_d = credit_q - CREDIT_W'(COIN_NICKEL);
                    change_d = 1'b1;
                    tmr_load = 1'b1;
                    tmr_val  = TMR_W'(CHG_GAP - 1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            credit_q   <= '0;
            dispense_q <= 1'b0;
            change_q   <= 1'b0;
            reject_q   <= 1'b0;
            insuff_q   <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            credit_q   <= credit_d;
            dispense_q <= (state_d == DISPENSE);
            change_q   <= change_d;
            reject_q   <= reject_d;
            insuff_q   <= insuff_d;
            busy_q     <= (state_d != IDLE);
        end
    end

    always_comb begin
        bus.credit        = credit_q;
        bus.dispense      = dispense_q;
        bus.change_nickel = change_q;
        bus.coin_reject   = reject_q;
        bus.insufficient  = insuff_q;
        bus.busy          = busy_q;
    end

endmodule

// File: tb/tb_candy_vend_fsm.sv
// Directed bench for candy_vend_fsm; flags = {dispense, change_nickel, coin_reject, insufficient, busy}.
module tb_candy_vend_fsm;

    logic clk;
    logic reset;
    int   vectors;
    int   errors;
    logic [12:0] obs;
    logic [12:0] want;

    candy_vend_fsm_if #(.CREDIT_W(8)) bus ();

    candy_vend_fsm dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign obs = {bus.credit, bus.dispense, bus.change_nickel, bus.coin_reject,
                  bus.insufficient, bus.busy};

    task automatic apply(input logic c5, input logic c10, input logic c25,
                         input logic sel, input logic can);
        bus.coin_5  = c5;
        bus.coin_10 = c10;
        bus.coin_25 = c25;
        bus.select  = sel;
        bus.cancel  = can;
        @(negedge clk);
        bus.coin_5  = 1'b0;
        bus.coin_10 = 1'b0;
        bus.coin_25 = 1'b0;
        bus.select  = 1'b0;
        bus.cancel  = 1'b0;
    endtask

    // Counts change pulses until busy drops, bounded at 200 cycles.
    task automatic run_change(output int pulses);
        pulses = 0;
        for (int i = 0; i < 200 && bus.busy; i++) begin
            if (bus.change_nickel) pulses++;
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        want = {8'd0, 5'b00000};
        vectors++;
        if (obs !== want) begin
            errors++;
            $display("FAIL reset_state: credit=%0d flags=%b expected credit=%0d flags=%b",
                     obs[12:5], obs[4:0], want[12:5], want[4:0]);
        end
    endtask

    task automatic test_exact_price();
        logic [7:0] seq [4];
        seq[0] = 8'd25; seq[1] = 8'd50; seq[2] = 8'd60; seq[3] = 8'd65;
        for (int i = 0; i < 4; i++) begin
            case (i)
                0, 1:    apply(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
                2:       apply(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
                default: apply(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
            endcase
            want = {seq[i], 5'b00000};
            vectors++;
            if (obs !== want) begin
                errors++;
                $display("FAIL exact_coin%0d: credit=%0d flags=%b expected credit=%0d flags=%b",
                         i, obs[12:5], obs[4:0], want[12:5], want[4:0]);
            end
        end
        apply(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 5; i++) begin
            want = (i < 4) ? {8'd0, 5'b10001} : {8'd0, 5'b00000};
            vectors++;
            if (obs !== want) begin
                errors++;
                $display("FAIL exact_disp_cyc%0d: credit=%0d flags=%b expected credit=%0d flags=%b",
                         i + 1, obs[12:5], obs[4:0], want[12:5], want[4:0]);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_dispense_change();
        logic [12:0] exp_seq [10];
        apply(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        apply(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        apply(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        want = {8'd75, 5'b00000};
        vectors++;
        if (obs !== want) begin
            errors++;
            $display("FAIL three_quarters: credit=%0d flags=%b expected credit=%0d flags=%b",
                     obs[12:5], obs[4:0], want[12:5], want[4:0]);
        end
        // Cycle 2 also carries a coin+select during dispense: rejected, ignored.
        exp_seq[0] = {8'd10, 5'b10001};
        exp_seq[1] = {8'd10, 5'b10101};
        exp_seq[2] = {8'd10, 5'b10001};
        exp_seq[3] = {8'd10, 5'b10001};
        exp_seq[4] = {8'd5,  5'b01001};
        exp_seq[5] = {8'd5,  5'b00001};
        exp_seq[6] = {8'd5,  5'b00001};
        exp_seq[7] = {8'd0,  5'b01001};
        exp_seq[8] = {8'd0,  5'b00000};
        exp_seq[9] = {8'd0,  5'b00000};
        apply(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 10; i++) begin
            want = exp_seq[i];
            vectors++;
            if (obs !== want) begin
                errors++;
                $display("FAIL change_seq_cyc%0d: credit=%0d flags=%b expected credit=%0d flags=%b",
                         i + 1, obs[12:5], obs[4:0], want[12:5], want[4:0]);
            end
            if (i == 0) apply(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
            else        @(negedge clk);
        end
    endtask

    task automatic test_overflow();
        int pulses;
        apply(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        want = {8'd15, 5'b00000};
        vectors++;
        if (obs !== want) begin
            errors++;
            $display("FAIL dime_nickel_sum: credit=%0d flags=%b expected credit=%0d flags=%b",
                     obs[12:5], obs[4:0], want[12:5], want[4:0]);
        end
        apply(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        apply(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        apply(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        apply(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        want = {8'd90, 5'b00100};
        vectors++;
        if (obs !== want) begin
            errors++;
            $display("FAIL overflow_reject: credit=%0d flags=%b expected credit=%0d flags=%b",
                     obs[12:5], obs[4:0], want[12:5], want[4:0]);
        end
        apply(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        want = {8'd100, 5'b00000};
        vectors++;
        if (obs !== want) begin
            errors++;
            $display("FAIL fill_to_max: credit=%0d flags=%b expected credit=%0d flags=%b",
                     obs[12:5], obs[4:0], want[12:5], want[4:0]);
        end
        apply(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        want = {8'd100, 5'b00100};
        vectors++;
        if (obs !== want) begin
            errors++;
            $display("FAIL nickel_over_max: credit=%0d flags=%b expected credit=%0d flags=%b",
                     obs[12:5], obs[4:0], want[12:5], want[4:0]);
        end
        apply(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        run_change(pulses);
        vectors++;
        if (pulses != 20 || obs !== {8'd0, 5'b00000}) begin
            errors++;
            $display("FAIL refund_100: pulses=%0d credit=%0d flags=%b expected pulses=20 credit=0 flags=00000",
                     pulses, obs[12:5], obs[4:0]);
        end
    endtask

    task automatic test_insufficient();
        int pulses;
        apply(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        apply(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        want = {8'd40, 5'b00010};
        vectors++;
        if (obs !== want) begin
            errors++;
            $display("FAIL insufficient_40: credit=%0d flags=%b expected credit=%0d flags=%b",
                     obs[12:5], obs[4:0], want[12:5], want[4:0]);
        end
        apply(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        want = {8'd35, 5'b01001};
        vectors++;
        if (obs !== want) begin
            errors++;
            $display("FAIL cancel_entry: credit=%0d flags=%b expected credit=%0d flags=%b",
                     obs[12:5], obs[4:0], want[12:5], want[4:0]);
        end
        run_change(pulses);
        vectors++;
        if (pulses != 8 || obs !== {8'd0, 5'b00000}) begin
            errors++;
            $display("FAIL refund_40: pulses=%0d credit=%0d flags=%b expected pulses=8 credit=0 flags=00000",
                     pulses, obs[12:5], obs[4:0]);
        end
    endtask

    task automatic test_cancel_priority();
        int pulses;
        apply(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        want = {8'd0, 5'b00000};
        vectors++;
        if (obs !== want) begin
            errors++;
            $display("FAIL cancel_zero: credit=%0d flags=%b expected credit=%0d flags=%b",
                     obs[12:5], obs[4:0], want[12:5], want[4:0]);
        end
        apply(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        want = {8'd0, 5'b00100};
        vectors++;
        if (obs !== want) begin
            errors++;
            $display("FAIL cancel_coin_reject: credit=%0d flags=%b expected credit=%0d flags=%b",
                     obs[12:5], obs[4:0], want[12:5], want[4:0]);
        end
        apply(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        apply(1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
        want = {8'd70, 5'b00010};
        vectors++;
        if (obs !== want) begin
            errors++;
            $display("FAIL insufficient_with_coins: credit=%0d flags=%b expected credit=%0d flags=%b",
                     obs[12:5], obs[4:0], want[12:5], want[4:0]);
        end
        apply(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        want = {8'd65, 5'b01001};
        vectors++;
        if (obs !== want) begin
            errors++;
            $display("FAIL select_cancel: credit=%0d flags=%b expected credit=%0d flags=%b",
                     obs[12:5], obs[4:0], want[12:5], want[4:0]);
        end
        apply(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        want = {8'd65, 5'b00101};
        vectors++;
        if (obs !== want) begin
            errors++;
            $display("FAIL coin_during_change: credit=%0d flags=%b expected credit=%0d flags=%b",
                     obs[12:5], obs[4:0], want[12:5], want[4:0]);
        end
        run_change(pulses);
        vectors++;
        if (pulses != 13 || obs !== {8'd0, 5'b00000}) begin
            errors++;
            $display("FAIL refund_70: pulses=%0d (+1 at entry) credit=%0d flags=%b expected pulses=13 credit=0 flags=00000",
                     pulses, obs[12:5], obs[4:0]);
        end
    endtask

    task automatic test_reset_mid_dispense();
        apply(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        apply(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        apply(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        apply(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        @(negedge clk);
        want = {8'd10, 5'b10001};
        vectors++;
        if (obs !== want) begin
            errors++;
            $display("FAIL disp_cyc2: credit=%0d flags=%b expected credit=%0d flags=%b",
                     obs[12:5], obs[4:0], want[12:5], want[4:0]);
        end
        reset = 1'b1;
        #1;
        want = {8'd0, 5'b00000};
        vectors++;
        if (obs !== want) begin
            errors++;
            $display("FAIL async_reset: credit=%0d flags=%b expected credit=%0d flags=%b",
                     obs[12:5], obs[4:0], want[12:5], want[4:0]);
        end
        @(negedge clk);
        reset = 1'b0;
        apply(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        want = {8'd5, 5'b00000};
        vectors++;
        if (obs !== want) begin
            errors++;
            $display("FAIL after_reset_nickel: credit=%0d flags=%b expected credit=%0d flags=%b",
                     obs[12:5], obs[4:0], want[12:5], want[4:0]);
        end
    endtask

    initial begin
        vectors     = 0;
        errors      = 0;
        reset       = 1'b1;
        bus.coin_5  = 1'b0;
        bus.coin_10 = 1'b0;
        bus.coin_25 = 1'b0;
        bus.select  = 1'b0;
        bus.cancel  = 1'b0;
        @(negedge clk);
        @(negedge clk);
        test_reset();
        reset = 1'b0;
        @(negedge clk);
        test_exact_price();
        test_dispense_change();
        test_overflow();
        test_insufficient();
        test_cancel_priority();
        test_reset_mid_dispense();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

endmodule
